mem_stage_dmem_ctrl: RTL and testbench

//  Memory-stage controller between EX/MEM register and MEM/WB register. Drives a req/ack data-memory bus.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/mem_load_align.sv | 32 +++
 rtl/mem_stage_dmem_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mem_stage_dmem_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage data-memory controller:
// funct3 access codes, FSM state encoding and access-size decoding.
package mem_pkg;

    // Load/store funct3 encodings
    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    // Controller FSM encoding (kept as plain constants for legacy tools)
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } acc_size_e;

    // Size is carried in funct3[1:0]; the unused codes 011/110/111 fall to word.
    function automatic acc_size_e size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   size_of = SZ_BYTE;
            2'b01:   size_of = SZ_HALF;
            default: size_of = SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load alignment: picks the addressed byte/halfword out of the bus word
// and sign- or zero-extends it to 32 bits. Purely combinational.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfword selection only looks at off[1]; off[0] of a halfword is ignored.
    assign byte_sel = rdata_i[{off_i, 3'b000} +: 8];
    assign half_sel = rdata_i[{off_i[1], 4'b0000} +: 16];

    // Extend the selected lane by size; funct3[2] marks the unsigned forms
    always_comb begin
        // NOTE: every output gets a value before the case so no path can infer a latch.
        data_o = rdata_i;
        case (size_of(funct3_i))
            SZ_BYTE: data_o = funct3_i[2] ? {24'h0, byte_sel}
                                          : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: data_o = funct3_i[2] ? {16'h0, half_sel}
                                          : {{16{half_sel[15]}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_dmem_ctrl.sv
// Memory-stage controller: issues one req/ack data-memory access per load
// or store, stalls the pipeline until it completes, steers store lanes and
// extends load data for MEM/WB. A wait counter bounds the ACK wait and
// reports a bus error on expiry.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses
// are trapped (never issued) and flagged on OUT_MISALIGN.
module mem_stage_dmem_ctrl
    import mem_pkg::*;
#(
    parameter int ACK_TIMEOUT = 64,
    parameter int CNT_WIDTH   = 7
)(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IN_ALU_RESULT,
    input  logic [31:0] IN_RS2_DATA,
    input  logic [2:0]  IN_FUNCT3,
    input  logic        IN_MEM_READ,
    input  logic        IN_MEM_WRITE,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [31:0] DMEM_ADDR,
    output logic [31:0] DMEM_WDATA,
    output logic [3:0]  DMEM_BE,
    input  logic [31:0] DMEM_RDATA,
    input  logic        DMEM_ACK,
    output logic [31:0] OUT_DMEM_OUT,
    output logic        OUT_STALL,
    output logic        OUT_BUS_ERR,
    output logic        OUT_MISALIGN
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(ACK_TIMEOUT - 1);

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 req_q, req_d;
    logic                 we_q, we_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [3:0]           be_q, be_d;
    logic [1:0]           off_q, off_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [31:0]          dout_q, dout_d;
    logic                 bus_err_q, bus_err_d;

    logic                 access;
    logic                 misalign_det;
    acc_size_e            in_size;
    logic [1:0]           in_off;
    logic [3:0]           st_be;
    logic [31:0]          st_wdata;
    logic [31:0]          load_data;

    assign access  = IN_MEM_READ | IN_MEM_WRITE;
    assign in_size = size_of(IN_FUNCT3);
    assign in_off  = IN_ALU_RESULT[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q;

    assign misalign_det = ((in_size == SZ_HALF) && in_off[0]) ||
                          ((in_size == SZ_WORD) && (in_off != 2'b00));

    // Misalign flag pulses in the DONE cycle that follows a trapped access
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) misalign_q <= 1'b0;
        else       misalign_q <= (state_q == ST_IDLE) && access && misalign_det;
    end

    assign OUT_MISALIGN = misalign_q;
`else
    assign misalign_det = 1'b0;
    assign OUT_MISALIGN = 1'b0;
`endif

    // Store lane steering: replicate data across lanes, enable addressed bytes
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = IN_RS2_DATA;
        case (in_size)
            SZ_BYTE: begin
                st_be    = 4'b0001 << in_off;
                st_wdata = {4{IN_RS2_DATA[7:0]}};
            end
            SZ_HALF: begin
                st_be    = 4'b0011 << {in_off[1], 1'b0};
                st_wdata = {2{IN_RS2_DATA[15:0]}};
            end
            default: ;
        endcase
    end

    mem_load_align u_load_align (
        .rdata_i  (DMEM_RDATA),
        .off_i    (off_q),
        .funct3_i (funct3_q),
        .data_o   (load_data)
    );

    // FSM next state: issue from IDLE, wait for ACK or timeout, one DONE cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        off_d     = off_q;
        funct3_d  = funct3_q;
        dout_d    = dout_q;
        bus_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (misalign_det) begin
                        dout_d  = 32'h0;
                        state_d = ST_DONE;
                    end else begin
                        req_d    = 1'b1;
                        we_d     = IN_MEM_WRITE;
                        addr_d   = {IN_ALU_RESULT[31:2], 2'b00};
                        be_d     = IN_MEM_WRITE ? st_be : 4'b1111;
                        wdata_d  = IN_MEM_WRITE ? st_wdata : wdata_q;
                        off_d    = in_off;
                        funct3_d = IN_FUNCT3;
                        cnt_d    = '0;
                        state_d  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // ACK is tested first so it wins over a coincident timeout
                if (DMEM_ACK) begin
                    req_d   = 1'b0;
                    if (!we_q) dout_d = load_data;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d     = 1'b0;
                    dout_d    = 32'h0;
                    bus_err_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and bus registers; async reset also drops an in-flight request
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            be_q      <= 4'h0;
            off_q     <= 2'b00;
            funct3_q  <= 3'b000;
            dout_q    <= 32'h0;
            bus_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            off_q     <= off_d;
            funct3_q  <= funct3_d;
            dout_q    <= dout_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign DMEM_REQ     = req_q;
    assign DMEM_WE      = we_q;
    assign DMEM_ADDR    = addr_q;
    assign DMEM_WDATA   = wdata_q;
    assign DMEM_BE      = be_q;
    assign OUT_DMEM_OUT = dout_q;
    assign OUT_BUS_ERR  = bus_err_q;
    assign OUT_STALL    = (state_q == ST_WAIT) || ((state_q == ST_IDLE) && access);

endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
// Scoreboard bench for mem_stage_dmem_ctrl: stimulus pushes expected bus
// requests and completion results; a negedge monitor pops and compares.
module tb_mem_stage_dmem_ctrl;

    localparam int TO = 64;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wdata;
    } bus_exp_t;

    typedef struct {
        logic [31:0] dout;
        logic        err;
        logic        mis;
        string       name;
    } res_exp_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] IN_ALU_RESULT = 32'h0;
    logic [31:0] IN_RS2_DATA = 32'h0;
    logic [2:0]  IN_FUNCT3 = 3'b000;
    logic        IN_MEM_READ = 1'b0;
    logic        IN_MEM_WRITE = 1'b0;
    logic        DMEM_REQ, DMEM_WE;
    logic [31:0] DMEM_ADDR, DMEM_WDATA;
    logic [3:0]  DMEM_BE;
    logic [31:0] DMEM_RDATA = 32'h0;
    logic        DMEM_ACK = 1'b0;
    logic [31:0] OUT_DMEM_OUT;
    logic        OUT_STALL, OUT_BUS_ERR, OUT_MISALIGN;

    int n_cmp = 0;
    int n_err = 0;
    bus_exp_t bus_q[$];
    res_exp_t res_q[$];

    mem_stage_dmem_ctrl #(.ACK_TIMEOUT(TO), .CNT_WIDTH(7)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .IN_ALU_RESULT (IN_ALU_RESULT),
        .IN_RS2_DATA   (IN_RS2_DATA),
        .IN_FUNCT3     (IN_FUNCT3),
        .IN_MEM_READ   (IN_MEM_READ),
        .IN_MEM_WRITE  (IN_MEM_WRITE),
        .DMEM_REQ      (DMEM_REQ),
        .DMEM_WE       (DMEM_WE),
        .DMEM_ADDR     (DMEM_ADDR),
        .DMEM_WDATA    (DMEM_WDATA),
        .DMEM_BE       (DMEM_BE),
        .DMEM_RDATA    (DMEM_RDATA),
        .DMEM_ACK      (DMEM_ACK),
        .OUT_DMEM_OUT  (OUT_DMEM_OUT),
        .OUT_STALL     (OUT_STALL),
        .OUT_BUS_ERR   (OUT_BUS_ERR),
        .OUT_MISALIGN  (OUT_MISALIGN)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: bus-request scoreboard, request stability, completion scoreboard
    initial begin
        logic        prev_req = 1'b0;
        logic        prev_stall = 1'b0;
        logic        s_we = 1'b0;
        logic [31:0] s_addr = 32'h0;
        logic [31:0] s_wdata = 32'h0;
        logic [3:0]  s_be = 4'h0;
        bus_exp_t    b;
        res_exp_t    r;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                prev_req   = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (DMEM_REQ && !prev_req) begin
                    if (bus_q.size() == 0) begin
                        check("unexpected_req", 32'(DMEM_REQ), 32'h0);
                    end else begin
                        b = bus_q.pop_front();
                        check("bus_we", 32'(DMEM_WE), 32'(b.we));
                        check("bus_addr", DMEM_ADDR, b.addr);
                        check("bus_be", 32'(DMEM_BE), 32'(b.be));
                        if (b.chk_wdata) check("bus_wdata", DMEM_WDATA, b.wdata);
                    end
                end else if (DMEM_REQ && prev_req) begin
                    check("hold_fields",
                          {DMEM_ADDR[31:2], DMEM_WE, DMEM_BE[0]} ^ {DMEM_WDATA[31:1], DMEM_BE[3]},
                          {s_addr[31:2], s_we, s_be[0]} ^ {s_wdata[31:1], s_be[3]});
                    check("hold_be", 32'(DMEM_BE), 32'(s_be));
                end
                if (prev_stall && !OUT_STALL) begin
                    if (res_q.size() == 0) begin
                        check("unexpected_done", 32'h1, 32'h0);
                    end else begin
                        r = res_q.pop_front();
                        check({r.name, "_dout"}, OUT_DMEM_OUT, r.dout);
                        check({r.name, "_bus_err"}, 32'(OUT_BUS_ERR), 32'(r.err));
                        check({r.name, "_misalign"}, 32'(OUT_MISALIGN), 32'(r.mis));
                    end
                end else begin
                    check("no_stray_pulse", 32'({OUT_BUS_ERR, OUT_MISALIGN}), 32'h0);
                end
                prev_req   = DMEM_REQ;
                prev_stall = OUT_STALL;
                s_we       = DMEM_WE;
                s_addr     = DMEM_ADDR;
                s_wdata    = DMEM_WDATA;
                s_be       = DMEM_BE;
            end
        end
    end

    // One access from EX/MEM; ack_at = REQ cycle index of ACK, -1 = never
    task automatic access(input string nm, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [31:0] rdata,
                          input int ack_at, input bit issued,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_dout, input logic exp_err,
                          input logic exp_mis);
        int stalls = 0;
        int reqs = 0;
        int c = 0;
        bit done = 1'b0;
        int exp_stalls;
        int exp_reqs;
        if (issued)
            bus_q.push_back('{we: wr, addr: {addr[31:2], 2'b00}, be: exp_be,
                              wdata: exp_wdata, chk_wdata: wr});
        res_q.push_back('{dout: exp_dout, err: exp_err, mis: exp_mis, name: nm});
        IN_MEM_READ   = rd;
        IN_MEM_WRITE  = wr;
        IN_FUNCT3     = f3;
        IN_ALU_RESULT = addr;
        IN_RS2_DATA   = rs2;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge CLK);
            if (!OUT_STALL) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (DMEM_REQ) reqs++;
                @(posedge CLK);
                #1;
                DMEM_ACK   = (ack_at >= 0) && (c == ack_at);
                DMEM_RDATA = DMEM_ACK ? rdata : 32'h0BAD_BAD0;
                c++;
            end
        end
        exp_stalls = !issued ? 1 : (ack_at < 0 ? TO + 1 : ack_at + 2);
        exp_reqs   = !issued ? 0 : (ack_at < 0 ? TO : ack_at + 1);
        check({nm, "_completed"}, 32'(done), 32'h1);
        check({nm, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
        check({nm, "_req_cycles"}, 32'(reqs), 32'(exp_reqs));
        @(posedge CLK);
        #1;
        IN_MEM_READ  = 1'b0;
        IN_MEM_WRITE = 1'b0;
        DMEM_ACK     = 1'b0;
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_req"}, 32'(DMEM_REQ), 32'h0);
        check({nm, "_we"}, 32'(DMEM_WE), 32'h0);
        check({nm, "_addr"}, DMEM_ADDR, 32'h0);
        check({nm, "_wdata"}, DMEM_WDATA, 32'h0);
        check({nm, "_be"}, 32'(DMEM_BE), 32'h0);
        check({nm, "_dout"}, OUT_DMEM_OUT, 32'h0);
        check({nm, "_flags"}, 32'({OUT_STALL, OUT_BUS_ERR, OUT_MISALIGN}), 32'h0);
    endtask

    initial begin
        #2;
        check_reset_outputs("reset");
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        //     name      rd wr f3      addr          rs2           rdata         ack iss be       wdata         dout          err  mis
        access("lw_100",  1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 0);
        access("lb_103",  1, 0, 3'b000, 32'h103, 32'h0,        32'h80FFFF7F, 1, 1, 4'b1111, 32'h0,        32'hFFFFFF80, 0, 0);
        access("lbu_103", 1, 0, 3'b100, 32'h103, 32'h0,        32'h80FFFF7F, 0, 1, 4'b1111, 32'h0,        32'h00000080, 0, 0);
        access("lhu_102", 1, 0, 3'b101, 32'h102, 32'h0,        32'h80FFFF7F, 0, 1, 4'b1111, 32'h0,        32'h000080FF, 0, 0);
        access("lh_100",  1, 0, 3'b001, 32'h100, 32'h0,        32'h80FFFF7F, 0, 1, 4'b1111, 32'h0,        32'hFFFFFF7F, 0, 0);
        access("lb_100",  1, 0, 3'b000, 32'h100, 32'h0,        32'h80FFFF7F, 2, 1, 4'b1111, 32'h0,        32'h0000007F, 0, 0);
        access("sb_201",  0, 1, 3'b000, 32'h201, 32'h123456AB, 32'h0,        3, 1, 4'b0010, 32'hABABABAB, 32'h0000007F, 0, 0);
        access("sh_202",  0, 1, 3'b001, 32'h202, 32'h0000BEEF, 32'h0,        0, 1, 4'b1100, 32'hBEEFBEEF, 32'h0000007F, 0, 0);
        access("sw_300",  0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0,        0, 1, 4'b1111, 32'hCAFEF00D, 32'h0000007F, 0, 0);
        access("timeout", 1, 0, 3'b010, 32'h400, 32'h0,        32'h0,       -1, 1, 4'b1111, 32'h0,        32'h00000000, 1, 0);
        access("lw_104",  1, 0, 3'b010, 32'h104, 32'h0,        32'h12345678, 0, 1, 4'b1111, 32'h0,        32'h12345678, 0, 0);
        access("rw_both", 1, 1, 3'b010, 32'h308, 32'h11223344, 32'h0,        0, 1, 4'b1111, 32'h11223344, 32'h12345678, 0, 0);
        access("f3_011",  1, 0, 3'b011, 32'h10C, 32'h0,        32'hA5A5A5A5, 0, 1, 4'b1111, 32'h0,        32'hA5A5A5A5, 0, 0);
        access("ack_last",1, 0, 3'b010, 32'h110, 32'h0,        32'h0BADF00D, TO - 1, 1, 4'b1111, 32'h0,   32'h0BADF00D, 0, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        access("lw_102",  1, 0, 3'b010, 32'h102, 32'h0,        32'h55667788, 0, 0, 4'b1111, 32'h0,        32'h00000000, 0, 1);
        access("sh_201",  0, 1, 3'b001, 32'h201, 32'h0000ABCD, 32'h0,        0, 0, 4'b0011, 32'hABCDABCD, 32'h00000000, 0, 1);
`else
        access("lw_102",  1, 0, 3'b010, 32'h102, 32'h0,        32'h55667788, 0, 1, 4'b1111, 32'h0,        32'h55667788, 0, 0);
        access("sh_201",  0, 1, 3'b001, 32'h201, 32'h0000ABCD, 32'h0,        0, 1, 4'b0011, 32'hABCDABCD, 32'h55667788, 0, 0);
`endif

        // Reset in the middle of a WAIT: request drops at once, late ACK ignored
        bus_q.push_back('{we: 1'b0, addr: 32'h600, be: 4'b1111, wdata: 32'h0, chk_wdata: 1'b0});
        IN_MEM_READ   = 1'b1;
        IN_FUNCT3     = 3'b010;
        IN_ALU_RESULT = 32'h600;
        repeat (2) @(posedge CLK);
        #3;
        RESET       = 1'b1;
        IN_MEM_READ = 1'b0;
        #1;
        check("reset_req_drop", 32'(DMEM_REQ), 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        #1;
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        DMEM_ACK   = 1'b1;
        DMEM_RDATA = 32'hFFFFFFFF;
        @(posedge CLK);
        #1;
        DMEM_ACK = 1'b0;
        @(negedge CLK);
        check_reset_outputs("late_ack");
        @(posedge CLK);
        #1;

        access("lw_500",  1, 0, 3'b010, 32'h500, 32'h0,        32'h0F0F0F0F, 0, 1, 4'b1111, 32'h0,        32'h0F0F0F0F, 0, 0);

        repeat (3) @(posedge CLK);
        check("bus_queue_drained", 32'(bus_q.size()), 32'h0);
        check("result_queue_drained", 32'(res_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run always ends on its own
    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
